// File: rtl/dx_imm_stage_pkg.sv
// dx_pkg: shared definitions for the decode-to-execute immediate stage.
//   - opcode constants, instruction type encodings
//   - instruction field bit positions and widths
//   - dx_entry_t: decoded entry as held by the stage (pc, fields, type)
//   - dx_classify(): opcode -> instruction type
package dx_pkg;

    localparam int unsigned DX_DATA_W  = 32;
    localparam int unsigned DX_IMM_W   = 17;
    localparam int unsigned DX_TGT_W   = 27;
    localparam int unsigned DX_FIELD_W = 5;

    // Opcodes, instr[31:27]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    // Instruction type encodings presented on out_type
    localparam logic [1:0] TYPE_R   = 2'd0;
    localparam logic [1:0] TYPE_I   = 2'd1;
    localparam logic [1:0] TYPE_JI  = 2'd2;
    localparam logic [1:0] TYPE_JII = 2'd3;

    // Field LSB positions inside the instruction word
    localparam int unsigned OPC_LSB   = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned SHAMT_LSB = 7;
    localparam int unsigned ALUOP_LSB = 2;

    typedef struct packed {
        logic [DX_DATA_W-1:0]  pc;
        logic [DX_FIELD_W-1:0] opcode;
        logic [DX_FIELD_W-1:0] rd;
        logic [DX_FIELD_W-1:0] rs;
        logic [DX_FIELD_W-1:0] rt;
        logic [DX_FIELD_W-1:0] shamt;
        logic [DX_FIELD_W-1:0] aluop;
        logic [DX_IMM_W-1:0]   imm;
        logic [DX_TGT_W-1:0]   target;
        logic [1:0]            itype;
    } dx_entry_t;

    // Unlisted opcodes fall back to I-type so their immediate still reaches
    // the sign extender.
    function automatic logic [1:0] dx_classify(input logic [4:0] op);
        case (op)
            OP_RTYPE:                      return TYPE_R;
            OP_ADDI, OP_SW, OP_LW,
            OP_BNE, OP_BLT:                return TYPE_I;
            OP_J, OP_JAL, OP_SETX, OP_BEX: return TYPE_JI;
            OP_JR:                         return TYPE_JII;
            default:                       return TYPE_I;
        endcase
    endfunction

endpackage

// File: rtl/dx_imm_stage_if.sv
// dx_imm_stage_if: upstream (fetch) and downstream (execute) handshake bundle
// of the decode-to-execute stage.
//   slave  : the stage itself (accepts in_*, presents out_*)
//   master : the surrounding fetch/execute logic or a testbench
// Ports: in_valid/in_ready/in_instr/in_pc, out_valid/out_ready,
//        out_pc/out_opcode/out_rd/out_rs/out_rt/out_shamt/out_aluop,
//        out_imm/out_target/out_type.
interface dx_imm_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 17,
    parameter int unsigned TGT_W  = 27
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pc;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    logic [4:0]        out_opcode;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_shamt;
    logic [4:0]        out_aluop;
    logic [IMM_W-1:0]  out_imm;
    logic [TGT_W-1:0]  out_target;
    logic [1:0]        out_type;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs,
               out_rt, out_shamt, out_aluop, out_imm, out_target, out_type
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs,
               out_rt, out_shamt, out_aluop, out_imm, out_target, out_type
    );
endinterface

// File: rtl/dx_imm_stage_field_decode.sv
// dx_field_decode: combinational instruction -> decoded entry.
// Ports: instr (fetched word), pc (its PC), entry (decoded dx_entry_t).
// rt/shamt/aluop are populated only for R-type, imm only for I-type and
// target only for JI-type; every other field is forced to zero.
module dx_field_decode
    import dx_pkg::*;
(
    input  logic [DX_DATA_W-1:0] instr,
    input  logic [DX_DATA_W-1:0] pc,
    output dx_entry_t            entry
);

    always_comb begin
        entry        = '0;
        entry.pc     = pc;
        entry.opcode = instr[OPC_LSB +: DX_FIELD_W];
        entry.rd     = instr[RD_LSB +: DX_FIELD_W];
        entry.rs     = instr[RS_LSB +: DX_FIELD_W];
        entry.itype  = dx_classify(instr[OPC_LSB +: DX_FIELD_W]);
        case (entry.itype)
            TYPE_R: begin
                entry.rt    = instr[RT_LSB +: DX_FIELD_W];
                entry.shamt = instr[SHAMT_LSB +: DX_FIELD_W];
                entry.aluop = instr[ALUOP_LSB +: DX_FIELD_W];
            end
            TYPE_I:  entry.imm    = instr[DX_IMM_W-1:0];
            TYPE_JI: entry.target = instr[DX_TGT_W-1:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/dx_imm_stage.sv
// dx_imm_stage: decode-to-execute pipeline stage feeding the 17->32 sign
// extender. Instructions are decoded on the input side and held decoded, so
// out_* come straight from registers.
// Ports:
//   clock, reset_n (async, active low), flush (drop all held entries)
//   bus         : dx_imm_stage_if.slave (in_* handshake, out_* handshake+fields)
//   stall_count : saturating count of cycles with out_valid && !out_ready
// Build option: DX_IMM_SKID_EN selects a two-entry skid buffer with a
// registered in_ready; without it a single register with combinational
// in_ready = !out_valid || out_ready.
module dx_imm_stage
    import dx_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IMM_W   = 17,
    parameter int unsigned TGT_W   = 27,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    dx_imm_stage_if.slave      bus,
    output logic [STALL_W-1:0] stall_count
);

    dx_entry_t dec;
    dx_entry_t head;
    logic      head_valid;
    logic      accept;
    logic      drain;

    dx_field_decode u_decode (
        .instr (bus.in_instr),
        .pc    (bus.in_pc),
        .entry (dec)
    );

    assign drain = head_valid && bus.out_ready;

`ifdef DX_IMM_SKID_EN
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ready_q;
    dx_entry_t  tail;

    assign bus.in_ready = ready_q;
    assign accept       = bus.in_valid && ready_q;
    assign head_valid   = (state != ST_EMPTY);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !drain)      state_nxt = ST_FULL;
                else if (!accept && drain) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (drain) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (flush) state_nxt = ST_EMPTY;
    end

    // head is always the entry on out_*; tail only holds the second entry
    // taken while the head is stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b1;
            head    <= '0;
            tail    <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != ST_FULL);
            if (!flush) begin
                case (state)
                    ST_EMPTY: if (accept) head <= dec;
                    ST_ONE: begin
                        if (accept && drain) head <= dec;
                        else if (accept)     tail <= dec;
                    end
                    ST_FULL:  if (drain) head <= tail;
                    default: ;
                endcase
            end
        end
    end
`else
    logic valid_q;

    assign head_valid   = valid_q;
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            head    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            head    <= dec;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (head_valid && !bus.out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign bus.out_valid  = head_valid;
    assign bus.out_pc     = head.pc[DATA_W-1:0];
    assign bus.out_opcode = head.opcode;
    assign bus.out_rd     = head.rd;
    assign bus.out_rs     = head.rs;
    assign bus.out_rt     = head.rt;
    assign bus.out_shamt  = head.shamt;
    assign bus.out_aluop  = head.aluop;
    assign bus.out_imm    = head.imm[IMM_W-1:0];
    assign bus.out_target = head.target[TGT_W-1:0];
    assign bus.out_type   = head.itype;

endmodule

// File: doc/dx_imm_stage.md
Name: dx_imm_stage

Overview:
- Decode-to-execute pipeline stage directly upstream of the 17→32 sign extender.
- Registers fetched instructions with PC and splits them into opcode, register and immediate/target fields.
- Classifies instruction type and presents `out_imm` (17-bit) to the sign extender.
- Valid/ready handshakes on both sides, pipeline flush for branches, and a saturating stall counter for debug.

Parameters:
- DATA_W, 32, instruction/PC width
- IMM_W, 17, I-type immediate width (sign extender input)
- TGT_W, 27, JI-type target width
- STALL_W, 16, stall counter width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held entries (branch taken / jump)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  DATA_W  fetched instruction
- in_pc  in  DATA_W  PC of in_instr
- out_valid  out  1  decoded entry valid
- out_ready  in  1  execute stage accepts
- out_pc  out  DATA_W  PC of held instruction
- out_opcode  out  5  instr[31:27]
- out_rd  out  5  instr[26:22]
- out_rs  out  5  instr[21:17]
- out_rt  out  5  instr[16:12]; 0 unless R-type
- out_shamt  out  5  instr[11:7]; 0 unless R-type
- out_aluop  out  5  instr[6:2]; 0 unless R-type
- out_imm  out  IMM_W  instr[16:0] for I-type, else 0
- out_target  out  TGT_W  instr[26:0] for JI-type, else 0
- out_type  out  2  0=R, 1=I, 2=JI, 3=JII
- stall_count  out  STALL_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Reset (async, reset_n=0): all entries invalid; out_valid=0; all out_* fields 0; stall_count=0; in_ready=1 once reset deasserts.
- Transfer: input when in_valid && in_ready; output when out_valid && out_ready. Latency is 1 cycle from input transfer to out_valid.
- Decode is performed on the input side and stored decoded. Outputs come straight from registers, with no combinational path from in_instr to out_*.
- Type map by opcode:
  - 00000 → R
  - 00101, 00111, 01000, 00010, 00110 → I
  - 00001, 00011, 10101, 10110 → JI
  - 00100 → JII
  - any other opcode → I, with out_imm populated.
- Held outputs stay stable while out_valid && !out_ready.
- Flush: next cycle out_valid=0 and all entries dropped.
  - Flush overrides a simultaneous input transfer; the instruction is discarded.
  - stall_count is not cleared by flush.
- Simultaneous input and output transfer in the same cycle: no bubble, full throughput.
- stall_count increments by 1 per stall cycle, holds at 2^STALL_W−1, and clears only on reset.
- Reset mid-transfer: everything is lost and no partial state survives.

Optional Feature:
- Macro: DX_IMM_SKID_EN.
- Defined: two-entry skid buffer with FSM EMPTY/ONE/FULL.
  - in_ready is registered: in_ready = state≠FULL.
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without drain.
  - FULL→ONE on drain.
  - ONE→EMPTY on drain without accept.
  - FULL never accepts.
  - Flush → EMPTY from any state.
- Undefined: single register; in_ready = !out_valid || out_ready (combinational). out_valid follows the same rules.

Decomposition:
- Package dx_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_J, OP_JAL, OP_JR, OP_SETX, OP_BEX)
  - type encodings (TYPE_R/I/JI/JII)
  - field bit positions
  - decoded-entry struct layout (pc, fields, type)
- One sub-module, dx_field_decode: combinational instr → decoded entry. Used once at the input side and unit-testable.

Test Plan:
- Reset then addi: in_instr=0x2845FFFF, in_pc=0x10, out_ready=1 → next cycle out_valid=1, out_type=1, out_rd=1, out_rs=2, out_imm=0x1FFFF, out_target=0, out_pc=0x10.
- R-type: in_instr=0x00C22000 → out_type=0, out_rd=3, out_rs=1, out_rt=2, out_imm=0, out_aluop=0.
- Jump: in_instr=0x08000100 → out_type=2, out_target=0x0000100, out_imm=0.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 → outputs stable, stall_count=5.
  - With DX_IMM_SKID_EN: the second instruction is accepted, the third sees in_ready=0.
- Flush with in_valid=1 and a held entry → next cycle out_valid=0, the flushed instruction never appears, stall_count unchanged.
- Streaming: in_valid=1 and out_ready=1 for 8 back-to-back instructions → 8 outputs in 8 consecutive cycles, in order, PCs 0x0..0x7.
- Async reset asserted mid-stall → out_valid=0 and stall_count=0 immediately, without waiting for a clock edge.
